// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared state encoding, rule indices and default set/singleton constants
package fuzzy_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, DIV, DONE} state_t;

    localparam logic [1:0] RULE_LOW  = 2'd0;
    localparam logic [1:0] RULE_MED  = 2'd1;
    localparam logic [1:0] RULE_HIGH = 2'd2;

    localparam int DEF_W   = 8;
    localparam int DEF_A_L = 0;
    localparam int DEF_B_L = 20;
    localparam int DEF_C_L = 40;
    localparam int DEF_A_M = 30;
    localparam int DEF_B_M = 50;
    localparam int DEF_C_M = 70;
    localparam int DEF_A_H = 60;
    localparam int DEF_B_H = 80;
    localparam int DEF_C_H = 100;
    localparam int DEF_OUT_L = 85;
    localparam int DEF_OUT_M = 170;
    localparam int DEF_OUT_H = 255;

endpackage

// File: rtl/fuzzy_risk_engine_if.sv
// fuzzy_risk_engine_if: sample-in and result-out handshakes of the fuzzy risk engine
interface fuzzy_risk_engine_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] raw;
    logic [W-1:0] sow;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] risk;
    logic         no_rule;
    logic [1:0]   dominant;

    modport master (
        output in_valid, raw, sow, out_ready,
        input  in_ready, out_valid, risk, no_rule, dominant
    );

    modport slave (
        input  in_valid, raw, sow, out_ready,
        output in_ready, out_valid, risk, no_rule, dominant
    );
endinterface

// File: rtl/fuzzy_tri_mf.sv
// fuzzy_tri_mf: triangular membership of x against breakpoints (A,B,C), scaled to 2^W-1
module fuzzy_tri_mf #(
    parameter int W = 8,
    parameter int A = 0,
    parameter int B = 20,
    parameter int C = 40
) (
    input  logic [W-1:0] x_i,
    output logic [W-1:0] mu_o
);
    typedef logic [2*W-1:0] wide_t;
    localparam wide_t M = wide_t'((1 << W) - 1);

    wide_t x, rise, fall;

    assign x    = wide_t'(x_i);
    assign rise = (x - wide_t'(A)) * M / wide_t'(B - A);
    assign fall = (wide_t'(C) - x) * M / wide_t'(C - B);

    // rising edge includes the peak, falling edge stops short of C
    always_comb
        mu_o = (x > wide_t'(A) && x <= wide_t'(B)) ? W'(rise) :
               (x > wide_t'(B) && x <  wide_t'(C)) ? W'(fall) : '0;
endmodule

// File: rtl/fuzzy_risk_engine.sv
// fuzzy_risk_engine: min-AND fuzzy risk estimator with weighted-average defuzzification
module fuzzy_risk_engine
    import fuzzy_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int A_L   = DEF_A_L,
    parameter int B_L   = DEF_B_L,
    parameter int C_L   = DEF_C_L,
    parameter int A_M   = DEF_A_M,
    parameter int B_M   = DEF_B_M,
    parameter int C_M   = DEF_C_M,
    parameter int A_H   = DEF_A_H,
    parameter int B_H   = DEF_B_H,
    parameter int C_H   = DEF_C_H,
    parameter int OUT_L = DEF_OUT_L,
    parameter int OUT_M = DEF_OUT_M,
    parameter int OUT_H = DEF_OUT_H
) (
    input logic                clk,
    input logic                rst_n,
    fuzzy_risk_engine_if.slave bus
);
    localparam int NW = 2 * W + 2;
    localparam int DW = W + 2;
    localparam int CW = $clog2(W);
    typedef logic [NW-1:0] num_t;
    typedef logic [DW-1:0] den_t;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    state_t        state_q;
    logic [W-1:0]  raw_q, sow_q, risk_q;
    logic [W-1:0]  mu_lr, mu_ls, mu_mr, mu_ms, mu_hr, mu_hs;
    logic [W-1:0]  s_l, s_m, s_h;
    num_t          num_d;
    den_t          den_d, den_q, rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [DW:0]   sh;
    logic          ge;
    logic [1:0]    dom_d, dominant_q;
    logic [CW-1:0] cnt_q;
    logic          out_valid_q, no_rule_q;

    fuzzy_tri_mf #(.W(W), .A(A_L), .B(B_L), .C(C_L)) u_mf_lr (.x_i(raw_q), .mu_o(mu_lr));
    fuzzy_tri_mf #(.W(W), .A(A_L), .B(B_L), .C(C_L)) u_mf_ls (.x_i(sow_q), .mu_o(mu_ls));
    fuzzy_tri_mf #(.W(W), .A(A_M), .B(B_M), .C(C_M)) u_mf_mr (.x_i(raw_q), .mu_o(mu_mr));
    fuzzy_tri_mf #(.W(W), .A(A_M), .B(B_M), .C(C_M)) u_mf_ms (.x_i(sow_q), .mu_o(mu_ms));
    fuzzy_tri_mf #(.W(W), .A(A_H), .B(B_H), .C(C_H)) u_mf_hr (.x_i(raw_q), .mu_o(mu_hr));
    fuzzy_tri_mf #(.W(W), .A(A_H), .B(B_H), .C(C_H)) u_mf_hs (.x_i(sow_q), .mu_o(mu_hs));

    // rule strengths, weighted sums and strongest rule (ties go to the lower index)
    always_comb begin
        s_l   = mu_lr < mu_ls ? mu_lr : mu_ls;
        s_m   = mu_mr < mu_ms ? mu_mr : mu_ms;
        s_h   = mu_hr < mu_hs ? mu_hr : mu_hs;
        num_d = num_t'(s_l) * num_t'(OUT_L) + num_t'(s_m) * num_t'(OUT_M) + num_t'(s_h) * num_t'(OUT_H);
        den_d = den_t'(s_l) + den_t'(s_m) + den_t'(s_h);
        dom_d = (s_h > s_l && s_h > s_m) ? RULE_HIGH : (s_m > s_l) ? RULE_MED : RULE_LOW;
    end

    // one restoring step: quo_q shifts dividend bits out at the top and quotient bits in at the bottom
    always_comb begin
        sh    = {rem_q, quo_q[W-1]};
        ge    = sh >= {1'b0, den_q};
        rem_d = ge ? DW'(sh - {1'b0, den_q}) : DW'(sh);
        quo_d = {quo_q[W-2:0], ge};
    end

    // control FSM with datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            raw_q       <= '0;
            sow_q       <= '0;
            den_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            risk_q      <= '0;
            no_rule_q   <= 1'b0;
            dominant_q  <= RULE_LOW;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    raw_q   <= bus.raw;
                    sow_q   <= bus.sow;
                    state_q <= EVAL;
                end
                EVAL: begin
                    den_q      <= den_d;
                    rem_q      <= DW'(num_d >> W);
                    quo_q      <= W'(num_d);
                    dominant_q <= dom_d;
                    cnt_q      <= '0;
                    if (den_d == '0) begin
                        risk_q      <= '0;
                        no_rule_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        no_rule_q <= 1'b0;
                        state_q   <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        risk_q      <= quo_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = out_valid_q;
    assign bus.risk      = risk_q;
    assign bus.no_rule   = no_rule_q;
    assign bus.dominant  = dominant_q;
endmodule

// File: doc/fuzzy_risk_engine.md
Name: fuzzy_risk_engine

Overview:
Parametrised successor of the team's rain/soil-moisture fuzzy risk estimator. Two W-bit sensor samples are taken in over a valid/ready handshake. Each sample is fuzzified against three triangular sets (low/medium/high) and the matching rules are fired with a true min-AND. The output is defuzzified as a weighted average using a sequential restoring divider, one quotient bit per cycle. It sits between the sensor sampling front end and the irrigation/alert controller, which consumes the result over a valid/ready handshake with backpressure.

Parameters:
W, 8, sample, membership and risk width
A_L/B_L/C_L, 0/20/40, low-set triangle breakpoints (a<b<c, all <2^W)
A_M/B_M/C_M, 30/50/70, medium-set breakpoints
A_H/B_H/C_H, 60/80/100, high-set breakpoints
OUT_L/OUT_M/OUT_H, 85/170/255, rule output singletons (<2^W)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  sample pair valid
in_ready  out  1  engine idle, can accept a sample pair
raw  in  W  rainfall sample
sow  in  W  soil-moisture sample
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts the result
risk  out  W  defuzzified risk
no_rule  out  1  no rule fired (denominator zero)
dominant  out  2  index of strongest rule: 0=low, 1=medium, 2=high

Behaviour:
- Reset is on rst_n at a clk edge. On reset: state IDLE, in_ready=1, out_valid=0, risk=0, no_rule=0, dominant=0. All datapath registers are cleared.
- Reset mid-operation aborts the in-flight computation. No result is emitted.
- in_ready = (state==IDLE), driven combinationally from state.
- FSM IDLE: on in_valid&in_ready, register raw/sow and go to EVAL.
- FSM EVAL (1 cycle):
  - Compute memberships, strengths s_i, num and den; register them.
  - If den==0: risk=0, no_rule=1, go to DONE.
  - Else: no_rule=0, go to DIV.
- FSM DIV (exactly W cycles): restoring division num/den, MSB-first, one quotient bit per cycle. Then go to DONE.
- FSM DONE: out_valid=1. risk, no_rule and dominant stay stable until out_valid&out_ready, then go to IDLE. out_valid drops the cycle after acceptance.
- Latency from handshake edge to out_valid: W+2 cycles normally, 2 cycles when den==0.
- Throughput: one result per W+3 cycles minimum. No new input is accepted while busy or stalled.
- Membership for value x and triangle (a,b,c), width W, max M=2^W-1:
  - a<x<=b: (x-a)*M/(b-a)
  - b<x<c: (c-x)*M/(c-b)
  - otherwise 0
  - Integer division truncates. Intermediates are 2W bits wide.
- Strengths:
  - s_L = min(mu_L(raw), mu_L(sow))
  - s_M = min(mu_M(raw), mu_M(sow))
  - s_H = min(mu_H(raw), mu_H(sow))
- Arithmetic:
  - num = s_L*OUT_L + s_M*OUT_M + s_H*OUT_H, width 2W+2.
  - den = s_L + s_M + s_H, width W+2.
  - Quotient is guaranteed < 2^W, since num <= den*M, so W iterations suffice. No saturation is needed.
- dominant = index of the largest s_i, registered in EVAL. Ties resolve to the lower index. It is 0 when no_rule=1.
- Inputs change freely when not handshaking. Only the registered copies are used.

Decomposition:
- Package fuzzy_pkg holds:
  - state enum (IDLE, EVAL, DIV, DONE)
  - rule index constants (RULE_LOW=0, RULE_MED=1, RULE_HIGH=2)
  - default breakpoint and singleton constants
- Sub-module fuzzy_tri_mf: combinational, parametrised by W, A, B, C. Maps an x input to a mu output. Six instances.
- Divider stays inline in the FSM.

Test Plan:
- raw=20, sow=20 -> s_L=255, s_M=0, s_H=0; risk=85, no_rule=0, dominant=0; out_valid exactly 10 cycles after handshake.
- raw=80, sow=80 -> risk=255, dominant=2; raw=50, sow=50 -> risk=170, dominant=1.
- raw=35, sow=35 -> s_L=63, s_M=63; num=16065, den=126; risk=127, dominant=0 (tie resolves to lower index).
- raw=200, sow=10 -> all strengths 0; risk=0, no_rule=1, dominant=0; out_valid 2 cycles after handshake.
- Backpressure:
  - Stimulus: result valid, out_ready held 0 for 5 cycles, in_valid held 1 with new data.
  - Required: risk, no_rule and dominant stable; in_ready=0; second sample not accepted until the cycle after out_ready.
  - Then the second result is correct.
- Reset mid-DIV (assert rst_n=0 at DIV cycle 3):
  - Next cycle: in_ready=1, out_valid=0, risk=0.
  - No stale result appears afterwards.
